// File: rtl/pwm_ctrl_pkg.sv
// Shared types and default timing constants for the PWM control front-end.
// Also intended for reuse by the PWM generator.
package pwm_ctrl_pkg;

  // Press FSM states for one button channel.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } press_state_t;

  // Default timings at 100 MHz.
  localparam int unsigned DEB_CYCLES_10MS = 1_000_000;
  localparam int unsigned REPEAT_500MS    = 50_000_000;
  localparam int unsigned REPEAT_200MS    = 20_000_000;

endpackage

// File: rtl/duty_button_conditioner_if.sv
// Button-to-PWM bundle: raw buttons in, step pulses and debounced levels out.
//   master : button/board side (drives raw buttons, observes outputs)
//   slave  : conditioner side (samples raw buttons, drives pulses and levels)
interface duty_button_conditioner_if;

  logic btn_inc_raw;
  logic btn_dec_raw;
  logic increase_duty;
  logic decrease_duty;
  logic btn_inc_level;
  logic btn_dec_level;

  modport master (
    output btn_inc_raw, btn_dec_raw,
    input  increase_duty, decrease_duty, btn_inc_level, btn_dec_level
  );

  modport slave (
    input  btn_inc_raw, btn_dec_raw,
    output increase_duty, decrease_duty, btn_inc_level, btn_dec_level
  );

endinterface

// File: rtl/button_channel.sv
// One button: synchronizer chain, debouncer and press/auto-repeat FSM.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   raw        : asynchronous button input
//   freeze     : hold the repeat counter (button conflict)
//   level      : debounced level (registered)
//   pulse_req  : step request, decoded from registered state only
module button_channel
  import pwm_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEB_CYCLES_10MS,
  parameter int unsigned REPEAT_DELAY    = REPEAT_500MS,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_200MS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic freeze,
  output logic level,
  output logic pulse_req
);

  localparam int unsigned DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_SAT  = DEB_W'(DEBOUNCE_CYCLES);
  // Counters are loaded with N-1 so the zero-cycle pulse lands exactly N cycles later.
  localparam logic [RPT_W-1:0] DELAY_LOAD  = (REPEAT_DELAY == 0) ? '0 : RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LOAD = RPT_W'(REPEAT_PERIOD - 1);

  localparam logic [1:0] ST_IDLE   = 2'(IDLE);
  localparam logic [1:0] ST_HOLD   = 2'(HOLD);
  localparam logic [1:0] ST_REPEAT = 2'(REPEAT);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;
  logic                   r_db;
  logic [DEB_W-1:0]       r_deb_cnt;
  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic [RPT_W-1:0]       r_rpt_cnt;
  logic [RPT_W-1:0]       w_rpt_nxt;
  logic                   w_pulse;

  // Metastability synchronizer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Debouncer: accept a new level after DEBOUNCE_CYCLES consecutive differing cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db      <= 1'b0;
      r_deb_cnt <= '0;
    end else if (w_sync == r_db) begin
      r_deb_cnt <= '0;
    end else if (r_deb_cnt == DEB_LAST) begin
      r_db      <= ~r_db;
      r_deb_cnt <= '0;
    end else if (r_deb_cnt != DEB_SAT) begin
      r_deb_cnt <= r_deb_cnt + DEB_W'(1);
    end
  end

  // Press FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_rpt_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rpt_cnt <= w_rpt_nxt;
    end
  end

  // Press FSM next state. Release beats a same-cycle zero count; freeze only stops
  // the countdown, so a pulse falling due during a conflict is consumed (and masked upstream).
  always_comb begin
    w_state_nxt = r_state;
    w_rpt_nxt   = r_rpt_cnt;
    w_pulse     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_db) begin
          w_pulse     = 1'b1;
          w_state_nxt = ST_HOLD;
          w_rpt_nxt   = DELAY_LOAD;
        end
      end
      ST_HOLD: begin
        if (!r_db) begin
          w_state_nxt = ST_IDLE;
          w_rpt_nxt   = '0;
        end else if (REPEAT_DELAY != 0) begin
          if (r_rpt_cnt == '0) begin
            w_pulse     = 1'b1;
            w_state_nxt = ST_REPEAT;
            w_rpt_nxt   = PERIOD_LOAD;
          end else if (!freeze) begin
            w_rpt_nxt = r_rpt_cnt - RPT_W'(1);
          end
        end
      end
      ST_REPEAT: begin
        if (!r_db) begin
          w_state_nxt = ST_IDLE;
          w_rpt_nxt   = '0;
        end else if (r_rpt_cnt == '0) begin
          w_pulse   = 1'b1;
          w_rpt_nxt = PERIOD_LOAD;
        end else if (!freeze) begin
          w_rpt_nxt = r_rpt_cnt - RPT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_rpt_nxt   = '0;
      end
    endcase
  end

  assign level     = r_db;
  assign pulse_req = w_pulse;

endmodule

// File: rtl/duty_button_conditioner.sv
// Two-button front-end for the PWM generator's increase/decrease step inputs.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of duty_button_conditioner_if
//                (raw buttons in; registered step pulses and debounced levels out)
module duty_button_conditioner
  import pwm_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEB_CYCLES_10MS,
  parameter int unsigned REPEAT_DELAY    = REPEAT_500MS,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_200MS
) (
  input logic                       clk,
  input logic                       rst_n,
  duty_button_conditioner_if.slave  bus
);

  logic w_inc_level;
  logic w_dec_level;
  logic w_inc_req;
  logic w_dec_req;
  logic w_conflict;
  logic r_increase_duty;
  logic r_decrease_duty;

  // Both buttons accepted as held: suppress pulses and freeze repeat timing.
  assign w_conflict = w_inc_level & w_dec_level;

  button_channel #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_inc (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw       (bus.btn_inc_raw),
    .freeze    (w_conflict),
    .level     (w_inc_level),
    .pulse_req (w_inc_req)
  );

  button_channel #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_dec (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw       (bus.btn_dec_raw),
    .freeze    (w_conflict),
    .level     (w_dec_level),
    .pulse_req (w_dec_req)
  );

  // Registered, conflict-masked step pulses; a masked request is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_increase_duty <= 1'b0;
      r_decrease_duty <= 1'b0;
    end else begin
      r_increase_duty <= w_inc_req & ~w_conflict;
      r_decrease_duty <= w_dec_req & ~w_conflict;
    end
  end

  assign bus.increase_duty = r_increase_duty;
  assign bus.decrease_duty = r_decrease_duty;
  assign bus.btn_inc_level = w_inc_level;
  assign bus.btn_dec_level = w_dec_level;

endmodule

// File: tb/tb_duty_button_conditioner.sv
// Bench for duty_button_conditioner: directed scenarios plus random button
// activity, checked every cycle against a behavioural model. Instance m=0 has
// auto-repeat enabled, m=1 has it disabled; both see the same buttons.
module tb_duty_button_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int DLY  = 20;
  localparam int PER  = 8;
  localparam int MAXC = 1024;

  logic clk = 1'b0;
  logic rst_n;
  logic inc_raw;
  logic dec_raw;

  always #5 clk = ~clk;

  duty_button_conditioner_if if0 ();
  duty_button_conditioner_if if1 ();

  assign if0.btn_inc_raw = inc_raw;
  assign if0.btn_dec_raw = dec_raw;
  assign if1.btn_inc_raw = inc_raw;
  assign if1.btn_dec_raw = dec_raw;

  duty_button_conditioner #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(if0));

  duty_button_conditioner #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(0), .REPEAT_PERIOD(PER)
  ) dut_nr (.clk(clk), .rst_n(rst_n), .bus(if1));

  // Model state: [instance][button 0=inc,1=dec]
  bit sh    [2][2][SYNC];   // raw samples still travelling through the synchronizer
  bit mdb   [2][2];         // accepted level
  int run   [2][2];         // consecutive cycles the synchronized input disagreed
  bit held  [2][2];         // press in progress
  int ticks [2][2];         // unfrozen cycles elapsed since the last pulse
  int np    [2][2];         // pulses issued since the press began
  bit ep    [2][2];         // expected registered pulse
  bit act   [2][2][MAXC];   // observed pulses, per cycle

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int rep_delay(input int m);
    return (m == 0) ? DLY : 0;
  endfunction

  function automatic int cnt_p(input int m, input int b, input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++) if (c < MAXC && act[m][b][c]) n++;
    return n;
  endfunction

  function automatic int act_at(input int m, input int b, input int c);
    return (c < MAXC) ? int'(act[m][b][c]) : -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++)
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < SYNC; i++) sh[m][b][i] = 1'b0;
        mdb[m][b] = 1'b0; run[m][b] = 0; held[m][b] = 1'b0;
        ticks[m][b] = 0; np[m][b] = 0; ep[m][b] = 1'b0;
      end
  endtask

  // One clock edge of the behavioural model, using pre-edge values throughout.
  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      bit db0, db1, conf;
      db0 = mdb[m][0]; db1 = mdb[m][1];
      conf = db0 & db1;
      for (int b = 0; b < 2; b++) begin
        bit dbo, so, req;
        int thr;
        dbo = (b == 0) ? db0 : db1;
        so  = sh[m][b][SYNC-1];
        req = 1'b0;
        if (!held[m][b]) begin
          if (dbo) begin
            held[m][b] = 1'b1; ticks[m][b] = 0; np[m][b] = 0; req = 1'b1;
          end
        end else if (!dbo) begin
          held[m][b] = 1'b0;
        end else begin
          thr = (np[m][b] == 0) ? rep_delay(m) : PER;
          if (thr != 0) begin
            if (ticks[m][b] == thr - 1) begin
              req = 1'b1; ticks[m][b] = 0; np[m][b]++;
            end else if (!conf) begin
              ticks[m][b]++;
            end
          end
        end
        ep[m][b] = req & ~conf;
        if (so != dbo) begin
          run[m][b]++;
          if (run[m][b] == DEB) begin mdb[m][b] = ~dbo; run[m][b] = 0; end
        end else begin
          run[m][b] = 0;
        end
        for (int i = SYNC - 1; i > 0; i--) sh[m][b][i] = sh[m][b][i-1];
        sh[m][b][0] = (b == 0) ? inc_raw : dec_raw;
      end
    end
  endtask

  task automatic compare();
    for (int m = 0; m < 2; m++) begin
      logic [3:0] o;
      o = (m == 0) ? {if0.increase_duty, if0.decrease_duty, if0.btn_inc_level, if0.btn_dec_level}
                   : {if1.increase_duty, if1.decrease_duty, if1.btn_inc_level, if1.btn_dec_level};
      check_eq($sformatf("m%0d inc_pulse c%0d", m, cyc), int'(o[3]), int'(ep[m][0]));
      check_eq($sformatf("m%0d dec_pulse c%0d", m, cyc), int'(o[2]), int'(ep[m][1]));
      check_eq($sformatf("m%0d inc_level c%0d", m, cyc), int'(o[1]), int'(mdb[m][0]));
      check_eq($sformatf("m%0d dec_level c%0d", m, cyc), int'(o[0]), int'(mdb[m][1]));
      if (cyc < MAXC) begin
        act[m][0][cyc] = o[3];
        act[m][1][cyc] = o[2];
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      if (rst_n) model_edge();
      cyc++;
      #1;
      compare();
    end
  endtask

  initial begin
    int t, s, t2, r0, lo;
    rst_n = 1'b0; inc_raw = 1'b0; dec_raw = 1'b0;
    model_reset();
    for (int m = 0; m < 2; m++)
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < MAXC; c++) act[m][b][c] = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    compare();
    check_eq("reset inc_pulse", int'(if0.increase_duty), 0);
    check_eq("reset inc_level", int'(if0.btn_inc_level), 0);
    rst_n = 1'b1;
    cyc = 0;

    // Clean press: raw rises at edge 10, level at 16, pulse at 17
    step(10);
    inc_raw = 1'b1;
    step(6);
    check_eq("clean level@16", int'(if0.btn_inc_level), 1);
    check_eq("clean no pulse@16", int'(if0.increase_duty), 0);
    step(1);
    check_eq("clean pulse@17", int'(if0.increase_duty), 1);
    check_eq("clean dec quiet@17", int'(if0.decrease_duty), 0);
    t = cyc;

    // Auto-repeat while held, then release
    step(53);
    inc_raw = 1'b0;
    step(30);
    check_eq("rpt T", act_at(0, 0, t), 1);
    check_eq("rpt T+20", act_at(0, 0, t + 20), 1);
    check_eq("rpt T+28", act_at(0, 0, t + 28), 1);
    check_eq("rpt T+36", act_at(0, 0, t + 36), 1);
    check_eq("rpt T+44", act_at(0, 0, t + 44), 1);
    check_eq("rpt T+52", act_at(0, 0, t + 52), 1);
    check_eq("rpt count", cnt_p(0, 0, t, cyc), 6);
    check_eq("norpt count", cnt_p(1, 0, t, cyc), 1);
    check_eq("norpt T", act_at(1, 0, t), 1);
    check_eq("rpt dec quiet", cnt_p(0, 1, t, cyc), 0);

    // Bounce on dec: 2-cycle glitches never accepted
    lo = cyc;
    repeat (5) begin
      dec_raw = 1'b1; step(2);
      dec_raw = 1'b0; step(2);
    end
    step(10);
    check_eq("bounce no pulse", cnt_p(0, 1, lo, cyc), 0);
    check_eq("bounce level", int'(if0.btn_dec_level), 0);
    s = cyc;
    dec_raw = 1'b1;
    step(15);
    dec_raw = 1'b0;
    step(15);
    check_eq("stable dec pulse S+7", act_at(0, 1, s + 7), 1);
    check_eq("stable dec count", cnt_p(0, 1, s, cyc), 1);
    check_eq("stable dec count nr", cnt_p(1, 1, s, cyc), 1);

    // Conflict: dec pressed 5 cycles after the inc initial pulse
    inc_raw = 1'b1;
    step(7);
    t2 = cyc;
    check_eq("conf inc initial", int'(if0.increase_duty), 1);
    step(5);
    dec_raw = 1'b1;
    step(35);
    dec_raw = 1'b0;
    step(24);
    inc_raw = 1'b0;   // level falls just as the count expires: no pulse
    step(20);
    check_eq("conf resume T2+55", act_at(0, 0, t2 + 55), 1);
    check_eq("conf repeat T2+63", act_at(0, 0, t2 + 63), 1);
    check_eq("conf inc count", cnt_p(0, 0, t2, cyc), 3);
    check_eq("conf dec count", cnt_p(0, 1, t2, cyc), 0);
    check_eq("conf nr inc count", cnt_p(1, 0, t2, cyc), 1);
    check_eq("conf nr dec count", cnt_p(1, 1, t2, cyc), 0);

    // Reset mid-hold right after the first repeat pulse
    inc_raw = 1'b1;
    step(27);
    check_eq("pre-reset repeat", int'(if0.increase_duty), 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("reset abort pulse", int'(if0.increase_duty), 0);
    check_eq("reset abort level", int'(if0.btn_inc_level), 0);
    step(3);
    rst_n = 1'b1;
    r0 = cyc;
    step(10);
    check_eq("post-reset pulse R+7", act_at(0, 0, r0 + 7), 1);
    check_eq("post-reset count", cnt_p(0, 0, r0, cyc), 1);
    inc_raw = 1'b0;
    step(20);

    // Random button activity with occasional resets
    repeat (70) begin
      if ($urandom_range(0, 29) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        compare();
        step($urandom_range(1, 3));
        rst_n = 1'b1;
      end
      inc_raw = 1'($urandom_range(0, 1));
      dec_raw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) step($urandom_range(1, 4));
      else step($urandom_range(5, 60));
    end
    inc_raw = 1'b0; dec_raw = 1'b0;
    step(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
